// File: rtl/instr_mem_loader.sv
// Instruction memory for the single-cycle core with a software load port.
// Edge-triggered single-word writes, combinational fetch, sticky first-error status.
module instr_mem_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 mem_reset_n,
  input  logic                 i_running,
  input  logic                 i_wr_req,
  input  logic [31:0]          i_wr_data,
  input  logic [31:0]          i_wr_addr,
  input  logic [31:0]          i_fetch_addr,
  output logic [31:0]          o_fetch_instr,
  output logic                 o_load_busy,
  output logic                 o_load_done,
  output logic [CNT_WIDTH-1:0] o_wr_count,
  output logic                 o_err,
  output logic [1:0]           o_err_code
);

  localparam int unsigned AW      = $clog2(MEM_DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [31:0]     mem [MEM_DEPTH];
  logic            r_req_d;
  logic            req_edge;
  logic            clear;
  logic            accept;
  logic            reject;
  logic [1:0]      reject_code;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic            fetch_oob;

  assign clear    = ~s00_axi_aresetn | ~mem_reset_n;
  assign req_edge = i_wr_req & ~r_req_d;

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    reject      = 1'b0;
    reject_code = 2'd0;
    o_load_busy = 1'b0;
    o_load_done = 1'b0;
    case (state)
      IDLE: begin
        if (req_edge) begin
          if (i_running) begin
            reject      = 1'b1;
            reject_code = 2'd3;
          end else if (i_wr_addr[1:0] != 2'b00) begin
            reject      = 1'b1;
            reject_code = 2'd1;
          end else if ({2'b00, i_wr_addr[31:2]} >= DEPTH_W) begin
            reject      = 1'b1;
            reject_code = 2'd2;
          end else begin
            accept   = 1'b1;
            state_nx = WRITE;
          end
        end
      end
      WRITE: begin
        o_load_busy = 1'b1;
        state_nx    = DONE;
        if (req_edge) begin
          reject      = 1'b1;
          reject_code = 2'd3;
        end
      end
      DONE: begin
        o_load_done = 1'b1;
        state_nx    = IDLE;
        if (req_edge) begin
          reject      = 1'b1;
          reject_code = 2'd3;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (clear) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= NOP_WORD;
      state      <= IDLE;
      r_req_d    <= 1'b0;
      o_wr_count <= '0;
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
    end else begin
      r_req_d <= i_wr_req;
      state   <= state_nx;
      if (accept) begin
        wr_idx  <= i_wr_addr[AW+1:2];
        wr_data <= i_wr_data;
      end
      // Commit uses the captured index/data, so i_wr_* never reach the outputs directly.
      if (state == WRITE) begin
        mem[wr_idx] <= wr_data;
        if (o_wr_count != '1) o_wr_count <= o_wr_count + 1'b1;
      end
      if (reject) begin
        o_err <= 1'b1;
        if (!o_err) o_err_code <= reject_code;
      end
    end
  end

  always_comb begin
    fetch_oob     = ({2'b00, i_fetch_addr[31:2]} >= DEPTH_W);
    o_fetch_instr = fetch_oob ? NOP_WORD : mem[i_fetch_addr[AW+1:2]];
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based reference model.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          mem_reset_n;
  logic          i_running;
  logic          i_wr_req;
  logic [31:0]   i_wr_data;
  logic [31:0]   i_wr_addr;
  logic [31:0]   i_fetch_addr;
  logic [31:0]   o_fetch_instr;
  logic          o_load_busy;
  logic          o_load_done;
  logic [CW-1:0] o_wr_count;
  logic          o_err;
  logic [1:0]    o_err_code;

  instr_mem_loader #(
    .MEM_DEPTH (DEPTH),
    .NOP_WORD  (NOP),
    .CNT_WIDTH (CW)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .mem_reset_n     (mem_reset_n),
    .i_running       (i_running),
    .i_wr_req        (i_wr_req),
    .i_wr_data       (i_wr_data),
    .i_wr_addr       (i_wr_addr),
    .i_fetch_addr    (i_fetch_addr),
    .o_fetch_instr   (o_fetch_instr),
    .o_load_busy     (o_load_busy),
    .o_load_done     (o_load_done),
    .o_wr_count      (o_wr_count),
    .o_err           (o_err),
    .o_err_code      (o_err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write accepted at clock edge number A is busy in the
  // cycle after A, lands in memory and pulses done after edge A+1, and the
  // loader can take a new request again from edge A+3 on.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt  = 0;
  bit          m_err  = 0;
  logic [1:0]  m_code = 2'd0;
  bit          m_prev = 0;
  longint      m_n    = 0;
  longint      m_acc  = -10;
  int unsigned m_idx  = 0;
  logic [31:0] m_data = '0;
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          chk_en = 0;

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    int unsigned idx;
    idx = a >> 2;
    if (idx >= DEPTH) return NOP;
    return m_mem[idx];
  endfunction

  task automatic m_flag(input logic [1:0] c);
    if (!m_err) m_code = c;
    m_err = 1;
  endtask

  task automatic model_step();
    bit rise;
    m_n++;
    if (!aresetn || !mem_reset_n) begin
      foreach (m_mem[i]) m_mem[i] = NOP;
      m_cnt  = 0;
      m_err  = 0;
      m_code = 2'd0;
      m_prev = 0;
      m_acc  = -10;
    end else begin
      rise   = i_wr_req && !m_prev;
      m_prev = i_wr_req;
      if (m_n == m_acc + 1) begin
        m_mem[m_idx] = m_data;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (rise) begin
        if (m_n < m_acc + 3)                  m_flag(2'd3);
        else if (i_running)                   m_flag(2'd3);
        else if (i_wr_addr[1:0] != 2'b00)     m_flag(2'd1);
        else if ((i_wr_addr >> 2) >= DEPTH)   m_flag(2'd2);
        else begin
          m_acc  = m_n;
          m_idx  = i_wr_addr >> 2;
          m_data = i_wr_data;
        end
      end
    end
    m_busy = (m_n == m_acc);
    m_done = (m_n == m_acc + 1);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("fetch", o_fetch_instr, m_fetch(i_fetch_addr));
      chk("busy",  32'(o_load_busy), 32'(m_busy));
      chk("done",  32'(o_load_done), 32'(m_done));
      chk("count", 32'(o_wr_count), 32'(m_cnt));
      chk("err",   32'(o_err), 32'(m_err));
      chk("code",  32'(o_err_code), 32'(m_code));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d);
    i_wr_addr = a;
    i_wr_data = d;
    i_wr_req  = 1'b1;
    step();
    i_wr_req  = 1'b0;
  endtask

  task automatic clear_mem();
    mem_reset_n = 1'b0;
    step();
    mem_reset_n = 1'b1;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    i_fetch_addr = a;
    #1;
    chk(name, o_fetch_instr, exp);
  endtask

  task automatic status(input string name, input logic [31:0] cnt, input logic e,
                        input logic [1:0] code);
    chk({name, "_count"}, 32'(o_wr_count), cnt);
    chk({name, "_err"},   32'(o_err), 32'(e));
    chk({name, "_code"},  32'(o_err_code), 32'(code));
  endtask

  initial begin
    logic [31:0] lst;
    int          sel;
    aresetn      = 1'b0;
    mem_reset_n  = 1'b1;
    i_running    = 1'b0;
    i_wr_req     = 1'b0;
    i_wr_data    = '0;
    i_wr_addr    = '0;
    i_fetch_addr = '0;
    lst          = '0;
    step();
    chk_en = 1;
    step();
    aresetn = 1'b1;
    step();

    // 1: reset contents and status
    peek("t1_f0", 32'h0, 32'h00000013);
    peek("t1_f3fc", 32'h3FC, 32'h00000013);
    peek("t1_f400", 32'h400, 32'h00000013);
    chk("t1_busy", 32'(o_load_busy), 32'd0);
    chk("t1_done", 32'(o_load_done), 32'd0);
    status("t1", 32'd0, 1'b0, 2'd0);

    // 2: single write, latency and misaligned fetch
    issue(32'h8, 32'h00500093);
    chk("t2_busy", 32'(o_load_busy), 32'd1);
    chk("t2_done0", 32'(o_load_done), 32'd0);
    step();
    chk("t2_busy0", 32'(o_load_busy), 32'd0);
    chk("t2_done", 32'(o_load_done), 32'd1);
    chk("t2_count", 32'(o_wr_count), 32'd1);
    peek("t2_f8", 32'h8, 32'h00500093);
    step();
    chk("t2_done_end", 32'(o_load_done), 32'd0);
    peek("t2_fA", 32'hA, 32'h00500093);

    // 3: held level gives one write; edge during DONE is an overrun
    i_wr_addr = 32'hC;
    i_wr_data = 32'h00100113;
    i_wr_req  = 1'b1;
    repeat (10) step();
    i_wr_req = 1'b0;
    step();
    status("t3a", 32'd2, 1'b0, 2'd0);
    peek("t3_fC", 32'hC, 32'h00100113);
    issue(32'h14, 32'h11111111);
    step();
    i_wr_req = 1'b1;
    step();
    i_wr_req = 1'b0;
    status("t3b", 32'd3, 1'b1, 2'd3);
    step();

    // 4: first error code is kept, rejected writes have no effect
    clear_mem();
    status("t4clr", 32'd0, 1'b0, 2'd0);
    issue(32'h6, 32'hAAAAAAAA);
    status("t4a", 32'd0, 1'b1, 2'd1);
    step();
    issue(32'h400, 32'hBBBBBBBB);
    step();
    status("t4b", 32'd0, 1'b1, 2'd1);
    peek("t4_f4", 32'h4, 32'h00000013);
    peek("t4_f6", 32'h6, 32'h00000013);

    // 5: running rejects; running raised mid-write does not abort
    clear_mem();
    i_running = 1'b1;
    issue(32'h10, 32'h00A00113);
    status("t5a", 32'd0, 1'b1, 2'd3);
    i_running = 1'b0;
    step();
    issue(32'h10, 32'h00A00113);
    i_running = 1'b1;
    chk("t5_busy", 32'(o_load_busy), 32'd1);
    step();
    chk("t5_done", 32'(o_load_done), 32'd1);
    peek("t5_f10", 32'h10, 32'h00A00113);
    step();
    i_running = 1'b0;
    step();

    // 6: clear during a write aborts it and wipes memory
    clear_mem();
    for (int k = 0; k < 4; k++) begin
      issue(32'(k * 4), 32'h00001000 + 32'(k));
      step();
      step();
    end
    chk("t6_count4", 32'(o_wr_count), 32'd4);
    peek("t6_f8", 32'h8, 32'h00001002);
    issue(32'h20, 32'hCAFE0000);
    chk("t6_busy", 32'(o_load_busy), 32'd1);
    mem_reset_n = 1'b0;
    step();
    mem_reset_n = 1'b1;
    chk("t6_done", 32'(o_load_done), 32'd0);
    chk("t6_busy0", 32'(o_load_busy), 32'd0);
    status("t6", 32'd0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) peek("t6_fk", 32'(k * 4), 32'h00000013);
    peek("t6_f20", 32'h20, 32'h00000013);
    step();
    chk("t6_done_later", 32'(o_load_done), 32'd0);

    // randomized traffic, checked by the model every cycle
    for (int it = 0; it < 3000; it++) begin
      if (!i_wr_req) begin
        sel = $urandom_range(0, 9);
        if (sel <= 6)      i_wr_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (sel == 7) i_wr_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (sel == 8) i_wr_addr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
        else               i_wr_addr = $urandom;
        i_wr_data = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        i_wr_req = ~i_wr_req;
        if (i_wr_req) lst = i_wr_addr;
      end
      i_running   = ($urandom_range(0, 19) == 0);
      mem_reset_n = ($urandom_range(0, 199) != 0);
      aresetn     = ($urandom_range(0, 299) != 0);
      sel = $urandom_range(0, 9);
      if (sel <= 4)      i_fetch_addr = lst;
      else if (sel <= 8) i_fetch_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      else               i_fetch_addr = $urandom;
      step();
    end
    aresetn     = 1'b1;
    mem_reset_n = 1'b1;
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
